// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit and its ALU/datapath.
package mc_pkg;

    typedef enum logic [6:0] {
        S_IF   = 7'b0000001,
        S_IW   = 7'b0000010,
        S_ID   = 7'b0000100,
        S_EX   = 7'b0001000,
        S_LDST = 7'b0010000,
        S_RDW  = 7'b0100000,
        S_WB   = 7'b1000000
    } state_t;

    typedef enum logic [3:0] {
        CL_BAD, CL_ALU_R, CL_ALU_I, CL_LW, CL_SW,
        CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR
    } iclass_t;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS    = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [1:0] WBSRC_ALUOUT = 2'b00;
    localparam logic [1:0] WBSRC_MEM    = 2'b01;
    localparam logic [1:0] WBSRC_PC     = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct decode: instruction class plus the ALU op and B-operand select used in EX.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it has no handshakes.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] iclass,
    output logic [2:0] ex_aluop,
    output logic [1:0] ex_alusrcb,
    output logic       ex_shamt
);

    iclass_t cls;

    always_comb begin
        cls        = CL_BAD;
        ex_aluop   = ALU_ADD;
        ex_alusrcb = SRCB_IMM;
        ex_shamt   = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                ex_alusrcb = SRCB_RT;
                unique case (funct)
                    FN_ADDU: begin cls = CL_ALU_R; ex_aluop = ALU_ADD;  end
                    FN_SUBU: begin cls = CL_ALU_R; ex_aluop = ALU_SUB;  end
                    FN_AND:  begin cls = CL_ALU_R; ex_aluop = ALU_AND;  end
                    FN_OR:   begin cls = CL_ALU_R; ex_aluop = ALU_OR;   end
                    FN_SLT:  begin cls = CL_ALU_R; ex_aluop = ALU_SLT;  end
                    FN_SLTU: begin cls = CL_ALU_R; ex_aluop = ALU_SLTU; end
                    FN_SLL:  begin cls = CL_ALU_R; ex_aluop = ALU_SLL; ex_shamt = 1'b1; end
                    FN_JR:   cls = CL_JR;
                    default: cls = CL_BAD;
                endcase
            end
            OP_ADDIU: begin cls = CL_ALU_I; ex_aluop = ALU_ADD;  end
            OP_SLTI:  begin cls = CL_ALU_I; ex_aluop = ALU_SLT;  end
            OP_SLTIU: begin cls = CL_ALU_I; ex_aluop = ALU_SLTU; end
            OP_LUI:   begin cls = CL_ALU_I; ex_aluop = ALU_LUI;  end
            OP_LW:    cls = CL_LW;
            OP_SW:    cls = CL_SW;
            // Branches compare rs against rt through a subtract.
            OP_BEQ:   begin cls = CL_BEQ; ex_aluop = ALU_SUB; ex_alusrcb = SRCB_RT; end
            OP_BNE:   begin cls = CL_BNE; ex_aluop = ALU_SUB; ex_alusrcb = SRCB_RT; end
            OP_J:     cls = CL_J;
            OP_JAL:   cls = CL_JAL;
            default:  cls = CL_BAD;
        endcase
    end

    assign iclass = cls;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM driving ALU op, datapath selects and fetch/data memory handshakes.
// Latency: outputs combinational from state; 4 (branch/jump), 5 (ALU, sw), 7 (lw) cycles minimum.
// Backpressure: request valids hold until ack is sampled; each state waits on its own ack/valid.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int RESET_ON_BAD_OP = 0
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] IR,
    input  logic        Zero,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ack,
    input  logic        Inst_Valid,
    output logic        Inst_Ack,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic        Mem_Req_Ack,
    input  logic        Read_data_Valid,
    output logic        Read_data_Ack,
    output logic [2:0]  ALUop,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCWrite,
    output logic [1:0]  PCSource,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg
);

    // Both settings return to fetch today; the non-zero setting is reserved for a trap.
    localparam state_t BAD_OP_NEXT = (RESET_ON_BAD_OP != 0) ? S_IF : S_IF;

    state_t     state, state_nxt;
    iclass_t    iclass;
    logic [3:0] iclass_raw;
    logic [2:0] ex_aluop;
    logic [1:0] ex_alusrcb;
    logic       ex_shamt;
    logic       unused_ir;

    assign unused_ir = ^IR[25:6];

    mc_decode u_decode (
        .op         (IR[31:26]),
        .funct      (IR[5:0]),
        .iclass     (iclass_raw),
        .ex_aluop   (ex_aluop),
        .ex_alusrcb (ex_alusrcb),
        .ex_shamt   (ex_shamt)
    );

    assign iclass = iclass_t'(iclass_raw);

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IF;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        Inst_Req_Valid = 1'b0;
        Inst_Ack       = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        Read_data_Ack  = 1'b0;
        ALUop          = ALU_AND;
        ALUSrcA        = SRCA_PC;
        ALUSrcB        = SRCB_RT;
        PCWrite        = 1'b0;
        PCSource       = PCSRC_ALU;
        IRWrite        = 1'b0;
        RegWrite       = 1'b0;
        RegDst         = DST_RT;
        MemtoReg       = WBSRC_ALUOUT;
        // While reset is low every output stays quiet, even mid-handshake.
        if (resetn) begin
            unique case (state)
                S_IF: begin
                    Inst_Req_Valid = 1'b1;
                    if (Inst_Req_Ack) state_nxt = S_IW;
                end
                S_IW: begin
                    Inst_Ack = 1'b1;
                    if (Inst_Valid) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        PCSource  = PCSRC_ALU;
                        ALUSrcA   = SRCA_PC;
                        ALUSrcB   = SRCB_FOUR;
                        ALUop     = ALU_ADD;
                        state_nxt = S_ID;
                    end
                end
                S_ID: begin
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_IMM_SH2;
                    ALUop     = ALU_ADD;
                    state_nxt = (iclass == CL_BAD) ? BAD_OP_NEXT : S_EX;
                end
                S_EX: begin
                    ALUop   = ex_aluop;
                    ALUSrcB = ex_alusrcb;
                    ALUSrcA = ex_shamt ? SRCA_SHAMT : SRCA_RS;
                    unique case (iclass)
                        CL_LW, CL_SW: state_nxt = S_LDST;
                        CL_ALU_R, CL_ALU_I: state_nxt = S_WB;
                        CL_BEQ: begin
                            PCWrite   = Zero;
                            PCSource  = PCSRC_ALUOUT;
                            state_nxt = S_IF;
                        end
                        CL_BNE: begin
                            PCWrite   = ~Zero;
                            PCSource  = PCSRC_ALUOUT;
                            state_nxt = S_IF;
                        end
                        CL_J: begin
                            PCWrite   = 1'b1;
                            PCSource  = PCSRC_JUMP;
                            state_nxt = S_IF;
                        end
                        CL_JAL: begin
                            PCWrite   = 1'b1;
                            PCSource  = PCSRC_JUMP;
                            RegWrite  = 1'b1;
                            RegDst    = DST_R31;
                            MemtoReg  = WBSRC_PC;
                            state_nxt = S_IF;
                        end
                        CL_JR: begin
                            PCWrite   = 1'b1;
                            PCSource  = PCSRC_RS;
                            state_nxt = S_IF;
                        end
                        default: state_nxt = S_IF;
                    endcase
                end
                S_LDST: begin
                    MemRead  = (iclass == CL_LW);
                    MemWrite = (iclass == CL_SW);
                    if (Mem_Req_Ack) state_nxt = (iclass == CL_LW) ? S_RDW : S_IF;
                end
                S_RDW: begin
                    Read_data_Ack = 1'b1;
                    if (Read_data_Valid) state_nxt = S_WB;
                end
                S_WB: begin
                    RegWrite  = 1'b1;
                    RegDst    = (iclass == CL_ALU_R) ? DST_RD : DST_RT;
                    MemtoReg  = (iclass == CL_LW) ? WBSRC_MEM : WBSRC_ALUOUT;
                    state_nxt = S_IF;
                end
                default: state_nxt = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios plus random instructions against an instruction-level model.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] IR;
    logic        Zero;
    logic        Inst_Req_Valid, Inst_Req_Ack, Inst_Valid, Inst_Ack;
    logic        MemRead, MemWrite, Mem_Req_Ack, Read_data_Valid, Read_data_Ack;
    logic [2:0]  ALUop;
    logic [1:0]  ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg;
    logic        PCWrite, IRWrite, RegWrite;

    mc_ctrl_fsm #(.RESET_ON_BAD_OP(0)) dut (
        .clk(clk), .resetn(resetn), .IR(IR), .Zero(Zero),
        .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ack(Inst_Req_Ack),
        .Inst_Valid(Inst_Valid), .Inst_Ack(Inst_Ack),
        .MemRead(MemRead), .MemWrite(MemWrite), .Mem_Req_Ack(Mem_Req_Ack),
        .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack),
        .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCWrite(PCWrite), .PCSource(PCSource), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irv, iack, mrd, mwr, rdack, pcw, irw, rw;
        logic [2:0] aluop;
        logic [1:0] sa, sb, pcs, rd, m2r;
    } obs_t;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4;
    localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_BAD = 8;
    localparam int NSPEC = 19;
    localparam int MAXC = 64;

    typedef struct {
        string      name;
        logic [5:0] op, funct;
        bit         rtype;
        int         kind;
        logic [2:0] aluop;
        logic [1:0] sa, sb;
        bit         chk_alu, chk_a, wr;
        logic [1:0] rd, m2r;
    } spec_t;

    obs_t tr [0:MAXC-1];
    int   tr_len;
    bit   timed_out;
    int   checks = 0;
    int   failures = 0;

    function automatic obs_t sample_outs();
        obs_t o;
        o.irv = Inst_Req_Valid; o.iack = Inst_Ack; o.mrd = MemRead; o.mwr = MemWrite;
        o.rdack = Read_data_Ack; o.pcw = PCWrite; o.irw = IRWrite; o.rw = RegWrite;
        o.aluop = ALUop; o.sa = ALUSrcA; o.sb = ALUSrcB; o.pcs = PCSource;
        o.rd = RegDst; o.m2r = MemtoReg;
        return o;
    endfunction

    function automatic logic [20:0] all_outs();
        return {Inst_Req_Valid, Inst_Ack, MemRead, MemWrite, Read_data_Ack, PCWrite, IRWrite,
                RegWrite, ALUop, ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg};
    endfunction

    function automatic spec_t mk(string nm, logic [5:0] op, logic [5:0] fn, bit rt, int kind,
                                 logic [2:0] alu, logic [1:0] sa, logic [1:0] sb, bit chk,
                                 bit chka, bit wr, logic [1:0] rd, logic [1:0] m2r);
        spec_t s;
        s.name = nm; s.op = op; s.funct = fn; s.rtype = rt; s.kind = kind; s.aluop = alu;
        s.sa = sa; s.sb = sb; s.chk_alu = chk; s.chk_a = chka; s.wr = wr; s.rd = rd; s.m2r = m2r;
        return s;
    endfunction

    // Instruction-level behaviour table, written from the ISA description.
    function automatic spec_t lookup(int k);
        case (k)
            0:  return mk("addu",  6'h00, 6'h21, 1, K_ALU, 3'b010, 2'b01, 2'b00, 1, 1, 1, 2'b01, 2'b00);
            1:  return mk("subu",  6'h00, 6'h23, 1, K_ALU, 3'b110, 2'b01, 2'b00, 1, 1, 1, 2'b01, 2'b00);
            2:  return mk("and",   6'h00, 6'h24, 1, K_ALU, 3'b000, 2'b01, 2'b00, 1, 1, 1, 2'b01, 2'b00);
            3:  return mk("or",    6'h00, 6'h25, 1, K_ALU, 3'b001, 2'b01, 2'b00, 1, 1, 1, 2'b01, 2'b00);
            4:  return mk("slt",   6'h00, 6'h2A, 1, K_ALU, 3'b111, 2'b01, 2'b00, 1, 1, 1, 2'b01, 2'b00);
            5:  return mk("sltu",  6'h00, 6'h2B, 1, K_ALU, 3'b011, 2'b01, 2'b00, 1, 1, 1, 2'b01, 2'b00);
            6:  return mk("sll",   6'h00, 6'h00, 1, K_ALU, 3'b101, 2'b10, 2'b00, 1, 1, 1, 2'b01, 2'b00);
            7:  return mk("addiu", 6'h09, 6'h00, 0, K_ALU, 3'b010, 2'b01, 2'b10, 1, 1, 1, 2'b00, 2'b00);
            8:  return mk("slti",  6'h0A, 6'h00, 0, K_ALU, 3'b111, 2'b01, 2'b10, 1, 1, 1, 2'b00, 2'b00);
            9:  return mk("sltiu", 6'h0B, 6'h00, 0, K_ALU, 3'b011, 2'b01, 2'b10, 1, 1, 1, 2'b00, 2'b00);
            10: return mk("lui",   6'h0F, 6'h00, 0, K_ALU, 3'b100, 2'b00, 2'b10, 1, 0, 1, 2'b00, 2'b00);
            11: return mk("lw",    6'h23, 6'h00, 0, K_LW,  3'b010, 2'b01, 2'b10, 1, 1, 1, 2'b00, 2'b01);
            12: return mk("sw",    6'h2B, 6'h00, 0, K_SW,  3'b010, 2'b01, 2'b10, 1, 1, 0, 2'b00, 2'b00);
            13: return mk("beq",   6'h04, 6'h00, 0, K_BEQ, 3'b110, 2'b01, 2'b00, 1, 1, 0, 2'b00, 2'b00);
            14: return mk("bne",   6'h05, 6'h00, 0, K_BNE, 3'b110, 2'b01, 2'b00, 1, 1, 0, 2'b00, 2'b00);
            15: return mk("j",     6'h02, 6'h00, 0, K_J,   3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00);
            16: return mk("jal",   6'h03, 6'h00, 0, K_JAL, 3'b000, 2'b00, 2'b00, 0, 0, 1, 2'b10, 2'b10);
            17: return mk("jr",    6'h00, 6'h08, 1, K_JR,  3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00);
            default: return mk("bad", 6'h3F, 6'h00, 0, K_BAD, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00);
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        Inst_Req_Ack = 1'b0; Inst_Valid = 1'b0; Mem_Req_Ack = 1'b0; Read_data_Valid = 1'b0;
        #1;
    endtask

    // Plays fetch/data memory with fixed wait counts and records one instruction's outputs.
    // Entered and left 1 time unit after a falling edge in an IF cycle.
    task automatic run_instr(input logic [31:0] instr, input logic z,
                             input int d0, input int d1, input int d2, input int d3);
        int c0, c1, c2, c3;
        bit left_if, ir_load;
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; left_if = 0; ir_load = 0;
        tr_len = 0; timed_out = 0; Zero = z;
        for (int cyc = 0; cyc < MAXC; cyc++) begin
            if (!Inst_Req_Valid) left_if = 1;
            else if (left_if) return;
            Inst_Req_Ack    = Inst_Req_Valid && (c0 >= d0);
            Inst_Valid      = Inst_Ack && (c1 >= d1);
            Mem_Req_Ack     = (MemRead || MemWrite) && (c2 >= d2);
            Read_data_Valid = Read_data_Ack && (c3 >= d3);
            #1;
            tr[tr_len] = sample_outs();
            tr_len++;
            if (Inst_Req_Valid) c0++;
            if (Inst_Ack) c1++;
            if (MemRead || MemWrite) c2++;
            if (Read_data_Ack) c3++;
            ir_load = IRWrite;
            step();
            if (ir_load) begin IR = instr; #1; end
        end
        timed_out = 1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; IR = 32'h8C820004; Zero = 1'b1;
        Inst_Req_Ack = 1'b1; Inst_Valid = 1'b1; Mem_Req_Ack = 1'b1; Read_data_Valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (all_outs() !== 21'd0) begin
                failures++; $display("FAIL reset_outs cyc%0d got %h want 0", i, all_outs());
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        Inst_Req_Ack = 1'b0; Inst_Valid = 1'b0; Mem_Req_Ack = 1'b0; Read_data_Valid = 1'b0;
        #1;
        checks++;
        if (all_outs() !== {1'b1, 20'd0}) begin
            failures++; $display("FAIL reset_release got %h want %h", all_outs(), {1'b1, 20'd0});
        end
    endtask

    task automatic test_addu();
        run_instr(32'h00851021, 1'b0, 0, 0, 0, 0);
        checks++;
        if (timed_out || tr_len !== 5) begin
            failures++; $display("FAIL addu_len got %0d want 5 (timeout=%0d)", tr_len, timed_out);
        end
        checks++;
        if (tr[1].irw !== 1'b1) begin
            failures++; $display("FAIL addu_irwrite got %b want 1", tr[1].irw);
        end
        checks++;
        if ({tr[3].aluop, tr[3].sb} !== {3'b010, 2'b00}) begin
            failures++; $display("FAIL addu_ex got %b want 01000", {tr[3].aluop, tr[3].sb});
        end
        checks++;
        if ({tr[4].rw, tr[4].rd, tr[4].m2r} !== 5'b10100) begin
            failures++; $display("FAIL addu_wb got %b want 10100", {tr[4].rw, tr[4].rd, tr[4].m2r});
        end
    endtask

    task automatic test_lw_waits();
        int nrd;
        run_instr(32'h8C820004, 1'b0, 0, 0, 3, 2);
        nrd = 0;
        for (int c = 0; c < tr_len; c++) if (tr[c].mrd) nrd++;
        checks++;
        if (timed_out || tr_len !== 12) begin
            failures++; $display("FAIL lw_len got %0d want 12 (timeout=%0d)", tr_len, timed_out);
        end
        checks++;
        if (nrd !== 4 || {tr[4].mrd, tr[5].mrd, tr[6].mrd, tr[7].mrd} !== 4'hF) begin
            failures++; $display("FAIL lw_memread got %0d cycles want 4 in cycles 4..7", nrd);
        end
        checks++;
        if ({tr[11].rw, tr[11].m2r} !== 3'b101) begin
            failures++; $display("FAIL lw_wb got %b want 101", {tr[11].rw, tr[11].m2r});
        end
    endtask

    task automatic test_branch();
        logic [31:0] ir;
        logic z, taken;
        for (int b = 0; b < 2; b++) begin
            for (int zi = 0; zi < 2; zi++) begin
                ir = (b == 1) ? 32'h14850003 : 32'h10850003;
                z = (zi == 1);
                taken = (b == 1) ? !z : z;
                run_instr(ir, z, 0, 0, 0, 0);
                checks++;
                if (timed_out || tr_len !== 4) begin
                    failures++; $display("FAIL branch_len bne=%0d z=%0d got %0d want 4", b, zi, tr_len);
                end
                checks++;
                if ({tr[3].pcw, tr[3].pcs, tr[3].aluop} !== {taken, 2'b01, 3'b110}) begin
                    failures++;
                    $display("FAIL branch_ex bne=%0d z=%0d got %b want %b", b, zi,
                             {tr[3].pcw, tr[3].pcs, tr[3].aluop}, {taken, 2'b01, 3'b110});
                end
            end
        end
    endtask

    task automatic test_jal();
        run_instr(32'h0C000010, 1'b0, 0, 0, 0, 0);
        checks++;
        if (timed_out || tr_len !== 4) begin
            failures++; $display("FAIL jal_len got %0d want 4", tr_len);
        end
        checks++;
        if ({tr[3].pcw, tr[3].pcs, tr[3].rw, tr[3].rd, tr[3].m2r} !== 8'b1_10_1_10_10) begin
            failures++;
            $display("FAIL jal_ex got %b want 11011010",
                     {tr[3].pcw, tr[3].pcs, tr[3].rw, tr[3].rd, tr[3].m2r});
        end
    endtask

    task automatic test_bad_op();
        run_instr(32'hFC000000, 1'b1, 0, 0, 0, 0);
        checks++;
        if (timed_out || tr_len !== 3) begin
            failures++; $display("FAIL badop_len got %0d want 3", tr_len);
        end
        checks++;
        if ({tr[2].pcw, tr[2].rw, tr[2].irw, tr[2].mrd, tr[2].mwr} !== 5'd0) begin
            failures++;
            $display("FAIL badop_id got %b want 00000",
                     {tr[2].pcw, tr[2].rw, tr[2].irw, tr[2].mrd, tr[2].mwr});
        end
    endtask

    task automatic test_reset_iw();
        Inst_Req_Ack = 1'b1;
        step();
        checks++;
        if (Inst_Ack !== 1'b1) begin
            failures++; $display("FAIL rstiw_enter got Inst_Ack=%b want 1", Inst_Ack);
        end
        Inst_Valid = 1'b1; resetn = 1'b0;
        #1;
        checks++;
        if ({IRWrite, PCWrite} !== 2'b00) begin
            failures++; $display("FAIL rstiw_strobes got %b want 00", {IRWrite, PCWrite});
        end
        @(negedge clk);
        resetn = 1'b1; Inst_Valid = 1'b0;
        #1;
        checks++;
        if ({Inst_Req_Valid, Inst_Ack} !== 2'b10) begin
            failures++; $display("FAIL rstiw_after got %b want 10", {Inst_Req_Valid, Inst_Ack});
        end
    endtask

    task automatic test_reset_ldst();
        IR = 32'hAC820004; Zero = 1'b0;
        Inst_Req_Ack = 1'b1;
        step();
        Inst_Valid = 1'b1;
        step();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (MemWrite !== 1'b1) begin
                failures++; $display("FAIL ldst_hold cyc%0d got %b want 1", i, MemWrite);
            end
            if (i < 2) step();
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 21'd0) begin
            failures++; $display("FAIL ldst_rst got %h want 0", all_outs());
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if ({MemWrite, Inst_Req_Valid} !== 2'b01) begin
            failures++; $display("FAIL ldst_after got %b want 01", {MemWrite, Inst_Req_Valid});
        end
    endtask

    task automatic test_random();
        spec_t sp;
        int k, d0, d1, d2, d3, irw_idx, id_idx, ex_idx, exp_len, exp_mrd, exp_mwr, rw_idx;
        int n_irw, n_pcw, n_rw, n_mrd, n_mwr, rw_at;
        logic z, taken;
        logic [1:0] exp_pcs;
        logic [31:0] r, ir;
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, NSPEC - 1);
            sp = lookup(k);
            d0 = $urandom_range(0, 3); d1 = $urandom_range(0, 3);
            d2 = $urandom_range(0, 3); d3 = $urandom_range(0, 3);
            z = 1'($urandom_range(0, 1));
            r = $urandom();
            ir = {sp.op, r[25:6], (sp.rtype ? sp.funct : r[5:0])};

            irw_idx = d0 + d1 + 1;
            id_idx  = irw_idx + 1;
            ex_idx  = id_idx + 1;
            taken   = (sp.kind == K_BEQ && z) || (sp.kind == K_BNE && !z) ||
                      sp.kind == K_J || sp.kind == K_JAL || sp.kind == K_JR;
            exp_pcs = (sp.kind == K_JR) ? 2'b11 :
                      (sp.kind == K_J || sp.kind == K_JAL) ? 2'b10 : 2'b01;
            case (sp.kind)
                K_BAD:   exp_len = ex_idx;
                K_ALU:   exp_len = ex_idx + 2;
                K_SW:    exp_len = ex_idx + 1 + d2 + 1;
                K_LW:    exp_len = ex_idx + 1 + (d2 + 1) + (d3 + 1) + 1;
                default: exp_len = ex_idx + 1;
            endcase
            exp_mrd = (sp.kind == K_LW) ? d2 + 1 : 0;
            exp_mwr = (sp.kind == K_SW) ? d2 + 1 : 0;
            rw_idx  = (sp.kind == K_JAL) ? ex_idx : exp_len - 1;

            run_instr(ir, z, d0, d1, d2, d3);

            n_irw = 0; n_pcw = 0; n_rw = 0; n_mrd = 0; n_mwr = 0; rw_at = -1;
            for (int c = 0; c < tr_len; c++) begin
                if (tr[c].irw) n_irw++;
                if (tr[c].pcw) n_pcw++;
                if (tr[c].mrd) n_mrd++;
                if (tr[c].mwr) n_mwr++;
                if (tr[c].rw) begin n_rw++; rw_at = c; end
            end

            checks++;
            if (timed_out || tr_len != exp_len) begin
                failures++;
                $display("FAIL rand%0d %s len got %0d want %0d (d=%0d%0d%0d%0d timeout=%0d)",
                         n, sp.name, tr_len, exp_len, d0, d1, d2, d3, timed_out);
            end
            checks++;
            if (n_irw != 1 || {tr[irw_idx].irw, tr[irw_idx].pcw, tr[irw_idx].pcs, tr[irw_idx].sa,
                               tr[irw_idx].sb, tr[irw_idx].aluop} !== 11'b1_1_00_00_01_010) begin
                failures++;
                $display("FAIL rand%0d %s iw got n=%0d %b want 1 11000001010", n, sp.name, n_irw,
                         {tr[irw_idx].irw, tr[irw_idx].pcw, tr[irw_idx].pcs, tr[irw_idx].sa,
                          tr[irw_idx].sb, tr[irw_idx].aluop});
            end
            checks++;
            if ({tr[id_idx].sa, tr[id_idx].sb, tr[id_idx].aluop} !== 7'b00_11_010) begin
                failures++;
                $display("FAIL rand%0d %s id got %b want 0011010", n, sp.name,
                         {tr[id_idx].sa, tr[id_idx].sb, tr[id_idx].aluop});
            end
            checks++;
            if (n_pcw != 1 + int'(taken) || n_mrd != exp_mrd || n_mwr != exp_mwr) begin
                failures++;
                $display("FAIL rand%0d %s strobes got pcw=%0d rd=%0d wr=%0d want %0d %0d %0d",
                         n, sp.name, n_pcw, n_mrd, n_mwr, 1 + int'(taken), exp_mrd, exp_mwr);
            end
            checks++;
            if (n_rw != int'(sp.wr) || (sp.wr && (rw_at != rw_idx ||
                {tr[rw_idx].rd, tr[rw_idx].m2r} !== {sp.rd, sp.m2r}))) begin
                failures++;
                $display("FAIL rand%0d %s regwrite got n=%0d at %0d dst/m2r=%b want n=%0d at %0d %b",
                         n, sp.name, n_rw, rw_at, {tr[rw_idx].rd, tr[rw_idx].m2r},
                         sp.wr, rw_idx, {sp.rd, sp.m2r});
            end
            if (sp.chk_alu) begin
                checks++;
                if ({tr[ex_idx].aluop, tr[ex_idx].sb} !== {sp.aluop, sp.sb} ||
                    (sp.chk_a && tr[ex_idx].sa !== sp.sa)) begin
                    failures++;
                    $display("FAIL rand%0d %s ex_alu got op=%b a=%b b=%b want op=%b a=%b b=%b",
                             n, sp.name, tr[ex_idx].aluop, tr[ex_idx].sa, tr[ex_idx].sb,
                             sp.aluop, sp.sa, sp.sb);
                end
            end
            if (taken) begin
                checks++;
                if ({tr[ex_idx].pcw, tr[ex_idx].pcs} !== {1'b1, exp_pcs}) begin
                    failures++;
                    $display("FAIL rand%0d %s ex_pc got %b want %b", n, sp.name,
                             {tr[ex_idx].pcw, tr[ex_idx].pcs}, {1'b1, exp_pcs});
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addu();
        test_lw_waits();
        test_branch();
        test_jal();
        test_bad_op();
        test_reset_iw();
        test_reset_ldst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control unit for the single-issue MIPS core. It drives the shared ALU's `ALUop` and datapath mux selects, and sequences instruction fetch and data memory requests with valid/ack handshakes. Each instruction passes through a fixed state sequence. The block sits between the instruction register (IR), the ALU's `Zero` flag and the memory interface, and has no datapath registers of its own.

## Interface
Parameters:
- `RESET_ON_BAD_OP`, default 0: 1 makes an unsupported opcode return to IF with no side effects. 0 behaves identically; the parameter is reserved for a future trap.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `IR`  in  32  current instruction register contents. Fields used: `[31:26]` op, `[5:0]` funct.
- `Zero`  in  1  ALU zero flag, used in the branch EX state.
- `Inst_Req_Valid`  out  1  fetch request.
- `Inst_Req_Ack`  in  1  fetch request accepted.
- `Inst_Valid`  in  1  instruction data present.
- `Inst_Ack`  out  1  instruction data consumed.
- `MemRead`  out  1  load request; `MemWrite`  out  1  store request.
- `Mem_Req_Ack`  in  1  data request accepted.
- `Read_data_Valid`  in  1  load data present.
- `Read_data_Ack`  out  1  load data consumed.
- `ALUop`  out  3  encoding: 000 and, 001 or, 010 add, 011 sltu, 100 lui, 101 sll, 110 sub, 111 slt.
- `ALUSrcA`  out  2  00 PC, 01 rs, 10 shamt.
- `ALUSrcB`  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `PCWrite`  out  1.
- `PCSource`  out  2  00 ALU result, 01 ALUOut reg, 10 jump target, 11 rs.
- `IRWrite`  out  1.
- `RegWrite`  out  1.
- `RegDst`  out  2  00 rt, 01 rd, 10 r31.
- `MemtoReg`  out  2  00 ALUOut, 01 load data, 10 PC.

## Operation
States: IF, IW, ID, EX, LDST, RDW, WB. Encoding is one-hot.
- **IF**: `Inst_Req_Valid`=1. Move to IW on the edge where `Inst_Req_Ack`=1.
- **IW**: `Inst_Ack`=1. On `Inst_Valid`=1: `IRWrite`=1, `PCWrite`=1, `PCSource`=00, A=PC, B=4, `ALUop`=add. Then move to ID.
- **ID**: A=PC, B=imm<<2, `ALUop`=add (branch target to ALUOut). Next state is EX for a supported op; otherwise IF.
- **EX** (one cycle):
  - R-type: A=rs, or shamt for sll. B=rt. `ALUop` from funct: addu→add, subu→sub, and, or, slt, sltu, sll. Next WB.
  - addiu/lw/sw: A=rs, B=imm, add. Next LDST for lw/sw, else WB.
  - slti/sltiu: as addiu, with `ALUop` 111/011.
  - lui: `ALUop`=lui, B=imm. Next WB.
  - beq/bne: A=rs, B=rt, sub. `PCWrite` = `Zero` for beq, `~Zero` for bne. `PCSource`=01. Next IF.
  - j/jal: `PCWrite`=1, `PCSource`=10. For jal also `RegWrite`=1, `RegDst`=10, `MemtoReg`=10. Next IF.
  - jr: `PCWrite`=1, `PCSource`=11. Next IF.
- **LDST**: `MemRead` (lw) or `MemWrite` (sw) held until `Mem_Req_Ack`. On ack, sw goes to IF and lw goes to RDW.
- **RDW**: `Read_data_Ack`=1. On `Read_data_Valid`, go to WB.
- **WB**: `RegWrite`=1.
  - `RegDst`=01 for R-type, 00 otherwise.
  - `MemtoReg`=01 for lw, 00 otherwise.
  - Next IF.

## Timing
- Reset (`resetn`=0 sampled): state←IF. On the reset cycle, every output is 0 and `ALUop`=000. Reset mid-handshake abandons the request; no ack is awaited.
- Outputs are decoded combinationally from state, `IR`, `Zero` and handshake inputs. Single-cycle strobes (`PCWrite`, `IRWrite`, `RegWrite`) assert only in the handshake-completing cycle.
- Valid signals stay asserted until ack is sampled high and never drop early. When ack is already high on entry, the transition occurs on that same edge.
- Minimum latency with zero-wait acks:
  - R/I-type ALU: 5 cycles.
  - lw: 7 cycles.
  - sw: 5 cycles.
  - branch/jump: 4 cycles.
- `IR` must be stable from ID through WB. The FSM reads it only in ID, EX, LDST, RDW and WB.
- In IW, simultaneous `Inst_Valid` and reset: reset wins, so no `IRWrite` and no `PCWrite`.

## Structure
- Package `mc_pkg`:
  - state enum;
  - `ALUop` constants (shared with the ALU);
  - opcode/funct constants;
  - mux-select constants.
- One sub-module `mc_decode`: combinational op/funct → instruction class plus EX-state `ALUop`/`ALUSrcB`.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles. Required: all outputs 0, then `Inst_Req_Valid`=1 in the first cycle after release.
- addu (IR=0x00851021), zero-wait acks: `IRWrite` in cycle 2, EX `ALUop`=010 with `ALUSrcB`=00, WB `RegWrite`=1 with `RegDst`=01. Back in IF after 5 cycles.
- lw (IR=0x8C820004) with `Mem_Req_Ack` delayed 3 cycles and `Read_data_Valid` delayed 2 cycles:
  - `MemRead` stays high for exactly 4 cycles;
  - `RegWrite` with `MemtoReg`=01 in WB;
  - total 12 cycles.
- beq (IR=0x10850003):
  - `Zero`=1 → `PCWrite`=1, `PCSource`=01 in EX;
  - `Zero`=0 → `PCWrite`=0;
  - bne inverts both cases.
- jal (IR=0x0C000010): in EX, `PCWrite`=1, `PCSource`=10, `RegWrite`=1, `RegDst`=10, `MemtoReg`=10.
- Unsupported op 0x3F, plus reset asserted during LDST wait: ID→IF with no writes; reset during LDST returns to IF with `MemWrite`=0 the next cycle.
